// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM between fetch and load/store.
// Latency: grant is combinational; read data/ack returns the cycle after the accept.
// Backpressure: one accept per cycle, round-robin on contention; losers see ready low and hold.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  input  logic                  if_flush,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_valid,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_we,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  logic last_grant;
  logic pend_if;
  logic pend_d;
  logic grant_if;
  logic grant_d;

  // Pick at most one requester; on a tie the port that did not win last time goes.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (!reset) begin
      if (if_valid && d_valid) begin
        if (last_grant == GRANT_IF) grant_d  = 1'b1;
        else                        grant_if = 1'b1;
      end else begin
        grant_if = if_valid;
        grant_d  = d_valid;
      end
    end
  end

  assign if_ready  = grant_if;
  assign d_ready   = grant_d;

  // Fetch carries no write data, so the data port's payload is only forwarded when it owns the RAM.
  assign mem_en    = grant_if | grant_d;
  assign mem_addr  = grant_d ? d_addr : if_addr;
  assign mem_we    = grant_d ? d_we : 4'b0000;
  assign mem_wdata = grant_d ? d_wdata : '0;

  // Reset also masks responses whose accept landed on the edge just before it asserted.
  assign if_rvalid = pend_if & ~reset;
  assign d_rvalid  = pend_d & ~reset;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  // Remember the last winner and which requester owns next cycle's RAM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_IF;
      pend_if    <= 1'b0;
      pend_d     <= 1'b0;
    end else begin
      if (grant_if || grant_d) last_grant <= grant_d ? GRANT_D : GRANT_IF;
      pend_if <= grant_if & ~if_flush;
      pend_d  <= grant_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [9:0]  if_addr;
  logic        if_ready;
  logic        if_flush;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_valid;
  logic [9:0]  d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // bench-side preload port into the RAM model
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:1023];
  logic [31:0] model_mem [0:15];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM, read-before-write, with byte strobes
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    if_valid = 0; if_addr = '0; if_flush = 0;
    d_valid = 0; d_addr = '0; d_we = '0; d_wdata = '0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] v);
    pl_en = 1; pl_addr = a; pl_data = v;
    model_mem[a[3:0]] = v;
    @(posedge clk); #1;
    pl_en = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    if_valid = 1; if_addr = 10'd3; d_valid = 1; d_addr = 10'd4; d_we = 4'hF; d_wdata = 32'h55;
    @(negedge clk);
    checks++; if ({if_ready, d_ready, mem_en, mem_we} !== 7'b0) begin
      errors++; $display("FAIL reset_gating: ready/en/we=%b required 0", {if_ready, d_ready, mem_en, mem_we});
    end
    @(posedge clk); #1;
    reset = 0; idle_inputs();
    @(negedge clk);
    checks++; if ({if_ready, d_ready, mem_en, mem_we, if_rvalid, d_rvalid} !== 9'b0) begin
      errors++; $display("FAIL reset_idle: outputs=%b required 0", {if_ready, d_ready, mem_en, mem_we, if_rvalid, d_rvalid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_only();
    preload(10'd5, 32'h00000013);
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (i < 3) begin if_valid = 1; if_addr = 10'd5; end
      @(negedge clk);
      checks++; if (if_ready !== (i < 3)) begin
        errors++; $display("FAIL fetch_ready[%0d]: got %b required %b", i, if_ready, (i < 3));
      end
      checks++; if (if_rvalid !== (i >= 1 && i <= 3)) begin
        errors++; $display("FAIL fetch_rvalid[%0d]: got %b required %b", i, if_rvalid, (i >= 1 && i <= 3));
      end
      if (i >= 1 && i <= 3) begin
        checks++; if (if_rdata !== 32'h00000013) begin
          errors++; $display("FAIL fetch_rdata[%0d]: got %h required 00000013", i, if_rdata);
        end
      end
      checks++; if (d_rvalid !== 1'b0) begin
        errors++; $display("FAIL fetch_d_rvalid[%0d]: got %b required 0", i, d_rvalid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    preload(10'd8, 32'hAAAAAAAA);
    idle_inputs();
    d_valid = 1; d_addr = 10'd8; d_we = 4'b0011; d_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if ({d_ready, mem_en, mem_we} !== 6'b110011) begin
      errors++; $display("FAIL wr_accept: ready,en,we=%b required 110011", {d_ready, mem_en, mem_we});
    end
    model_mem[8] = merge(model_mem[8], 32'h12345678, 4'b0011);
    @(posedge clk); #1;
    d_we = 4'b0000; d_wdata = '0;
    @(negedge clk);
    checks++; if ({d_rvalid, d_ready, mem_we} !== 6'b110000) begin
      errors++; $display("FAIL wr_ack: rvalid,ready,we=%b required 110000", {d_rvalid, d_ready, mem_we});
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hAAAA5678) begin
      errors++; $display("FAIL rd_after_wr: rvalid=%b rdata=%h required 1 AAAA5678", d_rvalid, d_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (i < 4) begin
        if_valid = 1; if_addr = 10'd5;
        d_valid = 1; d_addr = 10'd9; d_we = 4'b1100; d_wdata = 32'hCAFE0000 + i;
      end
      @(negedge clk);
      if (i < 4) begin
        checks++; if ({d_ready, if_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contend_grant[%0d]: d,if ready=%b%b", i, d_ready, if_ready);
        end
        checks++; if (mem_we !== ((i % 2 == 0) ? 4'b1100 : 4'b0000)) begin
          errors++; $display("FAIL contend_we[%0d]: got %b", i, mem_we);
        end
        if (i % 2 == 0) model_mem[9] = merge(model_mem[9], 32'hCAFE0000 + i, 4'b1100);
      end
      if (i >= 1) begin
        checks++; if ({d_rvalid, if_rvalid} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contend_resp[%0d]: d,if rvalid=%b%b", i, d_rvalid, if_rvalid);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    if_valid = 1; if_addr = 10'd5; if_flush = 1;
    @(negedge clk);
    checks++; if (if_ready !== 1'b1) begin
      errors++; $display("FAIL flush_accept: if_ready=%b required 1", if_ready);
    end
    @(posedge clk); #1;
    if_flush = 0;
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0 || if_ready !== 1'b1) begin
      errors++; $display("FAIL flush_drop: rvalid=%b ready=%b required 0 1", if_rvalid, if_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00000013) begin
      errors++; $display("FAIL flush_next: rvalid=%b rdata=%h required 1 00000013", if_rvalid, if_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    preload(10'd12, 32'h0);
    idle_inputs();
    d_valid = 1; d_addr = 10'd12; d_we = 4'hF; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (d_ready !== 1'b1) begin
      errors++; $display("FAIL rstw_accept: d_ready=%b required 1", d_ready);
    end
    model_mem[12] = 32'hDEADBEEF;
    @(posedge clk); #1;
    reset = 1; d_wdata = 32'h11111111;
    @(negedge clk);
    checks++; if ({d_rvalid, mem_en, mem_we, d_ready} !== 7'b0) begin
      errors++; $display("FAIL rstw_during: rvalid,en,we,ready=%b required 0", {d_rvalid, mem_en, mem_we, d_ready});
    end
    @(posedge clk); #1;
    reset = 0; d_we = 4'h0; d_wdata = '0;
    @(negedge clk);
    checks++; if (d_ready !== 1'b1 || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstw_read_accept: ready=%b rvalid=%b required 1 0", d_ready, d_rvalid);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rstw_readback: rvalid=%b rdata=%h required 1 deadbeef", d_rvalid, d_rdata);
    end
    @(posedge clk); #1;
  endtask

  // Random traffic against a transaction-level model: each unit holds a request until
  // it is accepted; ties alternate starting with data after reset.
  task automatic test_random();
    bit f_hold, dh_hold, data_wins_tie;
    logic [9:0] fa, da;
    logic [3:0] dwe;
    logic [31:0] dwd;
    bit exp_if_rv, exp_d_rv, exp_d_rd;
    logic [31:0] exp_if_dat, exp_d_dat;
    bit win_f, win_d, flush;
    for (int a = 0; a < 16; a++) preload(10'(a), $urandom);
    do_reset();
    f_hold = 0; dh_hold = 0; data_wins_tie = 1;
    exp_if_rv = 0; exp_d_rv = 0; exp_d_rd = 0; exp_if_dat = '0; exp_d_dat = '0;
    fa = '0; da = '0; dwe = '0; dwd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!f_hold && ($urandom % 3 != 0)) begin f_hold = 1; fa = 10'($urandom % 16); end
      if (!dh_hold && ($urandom % 3 != 0)) begin
        dh_hold = 1; da = 10'($urandom % 16); dwd = $urandom;
        dwe = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16);
      end
      flush = ($urandom % 5 == 0);
      if_valid = f_hold; if_addr = fa; if_flush = flush;
      d_valid = dh_hold; d_addr = da; d_we = dwe; d_wdata = dwd;
      if (f_hold && dh_hold) begin win_d = data_wins_tie; win_f = !data_wins_tie; end
      else begin win_f = f_hold; win_d = dh_hold; end
      @(negedge clk);
      checks++; if ({if_ready, d_ready, mem_en} !== {win_f, win_d, win_f | win_d}) begin
        errors++; $display("FAIL rnd_grant[%0d]: if,d,en=%b%b%b required %b%b%b", c,
                           if_ready, d_ready, mem_en, win_f, win_d, win_f | win_d);
      end
      checks++; if (mem_we !== (win_d ? dwe : 4'h0)) begin
        errors++; $display("FAIL rnd_we[%0d]: got %b required %b", c, mem_we, win_d ? dwe : 4'h0);
      end
      if (win_f || win_d) begin
        checks++; if (mem_addr !== (win_d ? da : fa)) begin
          errors++; $display("FAIL rnd_addr[%0d]: got %0d required %0d", c, mem_addr, win_d ? da : fa);
        end
      end
      if (win_d && dwe != 4'h0) begin
        checks++; if (mem_wdata !== dwd) begin
          errors++; $display("FAIL rnd_wdata[%0d]: got %h required %h", c, mem_wdata, dwd);
        end
      end
      checks++; if ({if_rvalid, d_rvalid} !== {exp_if_rv, exp_d_rv}) begin
        errors++; $display("FAIL rnd_rvalid[%0d]: if,d=%b%b required %b%b", c, if_rvalid, d_rvalid, exp_if_rv, exp_d_rv);
      end
      if (exp_if_rv) begin
        checks++; if (if_rdata !== exp_if_dat) begin
          errors++; $display("FAIL rnd_if_rdata[%0d]: got %h required %h", c, if_rdata, exp_if_dat);
        end
      end
      if (exp_d_rv && exp_d_rd) begin
        checks++; if (d_rdata !== exp_d_dat) begin
          errors++; $display("FAIL rnd_d_rdata[%0d]: got %h required %h", c, d_rdata, exp_d_dat);
        end
      end
      exp_if_rv = win_f && !flush;
      exp_d_rv = win_d;
      if (win_f) begin exp_if_dat = model_mem[fa[3:0]]; f_hold = 0; end
      if (win_d) begin
        exp_d_rd = (dwe == 4'h0);
        exp_d_dat = model_mem[da[3:0]];
        model_mem[da[3:0]] = merge(model_mem[da[3:0]], dwd, dwe);
        dh_hold = 0;
      end
      if (win_f || win_d) data_wins_tie = win_f;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    pl_en = 0; pl_addr = '0; pl_data = '0;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fetch_only();
    test_write_read();
    test_contention();
    test_flush();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
